// File: rtl/addsub_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_operand_sequencer
//  Description : Steps through operand A, operand B and the add/subtract
//                result with one debounced pushbutton. Drives the op symbol,
//                the carry/negative flag and the operand/result values.
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_operand_sequencer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_sel,
  input  logic             key_n,
  output logic             s,
  output logic             carryOut,
  output logic [WIDTH-1:0] operand_a,
  output logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [1:0]       state
);

  localparam int             CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'b00,
    ST_LOAD_B = 2'b01,
    ST_SHOW   = 2'b10
  } state_t;

  // Key path registers
  logic [1:0]       sync_q;
  logic             key_db_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       settle_q;
  logic             armed_q;

  // FSM and datapath registers
  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;
  logic             slat_q, slat_d;

  logic             key_sync;
  logic             press;
  logic [WIDTH:0]   sum;
  logic             a_lt_b;
  logic [WIDTH-1:0] diff;

  assign key_sync = sync_q[1];

  // A press is the debounced level being accepted as low while it was high.
  // armed_q blocks a key that was already held when reset was released.
  assign press = armed_q & key_db_q & ~key_sync & (cnt_q == CNT_MAX);

  // Synchronise the key, debounce it, and arm once a released level is seen
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      key_db_q <= 1'b1;
      cnt_q    <= '0;
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      if (key_sync == key_db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        key_db_q <= key_sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      // The synchroniser needs two clocks to reflect the real key level.
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end
      if ((settle_q == 2'd2) && key_sync && key_db_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sum    = {1'b0, opa_q} + {1'b0, sw};
  assign a_lt_b = (opa_q < sw);
  assign diff   = a_lt_b ? (sw - opa_q) : (opa_q - sw);

  // Next-state and datapath updates, advancing only on a press
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    valid_d = valid_q;
    slat_d  = slat_q;
    case (state_q)
      ST_LOAD_A: begin
        if (press) begin
          opa_d   = sw;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (press) begin
          opb_d  = sw;
          slat_d = op_sel;
          if (op_sel) begin
            carry_d = a_lt_b;
            res_d   = diff;
          end else begin
            carry_d = sum[WIDTH];
            res_d   = sum[WIDTH-1:0];
          end
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (press) begin
          valid_d = 1'b0;
          carry_d = 1'b0;
          state_d = ST_LOAD_A;
        end
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  // State and datapath register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD_A;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      slat_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
      slat_q  <= slat_d;
    end
  end

  // The symbol follows the switch until the result is shown, then freezes.
  assign s            = (state_q == ST_SHOW) ? slat_q : op_sel;
  assign carryOut     = carry_q;
  assign operand_a    = opa_q;
  assign operand_b    = opb_q;
  assign result       = res_q;
  assign result_valid = valid_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_addsub_operand_sequencer
//  Description : Directed bench for addsub_operand_sequencer with a
//                behavioural reference model and per-cycle output compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_operand_sequencer;

  localparam int W  = 4;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sw = '0;
  logic         op_sel = 1'b0;
  logic         key_n = 1'b1;
  logic         s;
  logic         carryOut;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [W-1:0] result;
  logic         result_valid;
  logic [1:0]   state;

  addsub_operand_sequencer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .op_sel(op_sel),
    .key_n(key_n),
    .s(s),
    .carryOut(carryOut),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .result(result),
    .result_valid(result_valid),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit busy  = 1'b1;

  // Reference model: step index 0/1/2 and the values the spec says must show.
  int m_step, m_a, m_b, m_res, m_c, m_valid, m_lat;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_step = 0; m_a = 0; m_b = 0; m_res = 0; m_c = 0; m_valid = 0; m_lat = 0;
  endtask

  task automatic model_press(input int v, input int op);
    if (m_step == 0) begin
      m_a    = v;
      m_step = 1;
    end else if (m_step == 1) begin
      m_b   = v;
      m_lat = op;
      if (op == 0) begin
        m_res = (m_a + m_b) % 16;
        m_c   = (m_a + m_b) >= 16 ? 1 : 0;
      end else if (m_a < m_b) begin
        m_res = m_b - m_a;
        m_c   = 1;
      end else begin
        m_res = m_a - m_b;
        m_c   = 0;
      end
      m_valid = 1;
      m_step  = 2;
    end else begin
      m_valid = 0;
      m_c     = 0;
      m_step  = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!busy) begin
      chk("state", int'(state), m_step);
      chk("operand_a", int'(operand_a), m_a);
      chk("operand_b", int'(operand_b), m_b);
      chk("result", int'(result), m_res);
      chk("carryOut", int'(carryOut), m_c);
      chk("result_valid", int'(result_valid), m_valid);
      chk("s", int'(s), (m_step == 2) ? m_lat : int'(op_sel));
    end
  end

  // Clean press: long low, then long high so the release also settles.
  task automatic press();
    busy  = 1'b1;
    key_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    model_press(int'(sw), int'(op_sel));
    busy = 1'b0;
  endtask

  // Short low pulse that must be rejected; outputs stay under compare.
  task automatic bounce(input int n);
    key_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    busy  = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    busy = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    busy = 1'b0;

    // Reset with key released: idle, no spurious step
    wait_cycles(8);
    chk("rst_state", int'(state), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(result_valid), 0);
    chk("rst_carry", int'(carryOut), 0);

    // Add with carry: 9 + 8 = 17
    op_sel = 1'b0; sw = 4'd9; press();
    sw = 4'd8; press();
    chk("add_state", int'(state), 2);
    chk("add_result", int'(result), 1);
    chk("add_carry", int'(carryOut), 1);
    chk("add_s", int'(s), 0);
    chk("add_valid", int'(result_valid), 1);
    press();

    // Subtract negative: 3 - 5, then op_sel toggled while showing
    op_sel = 1'b1; sw = 4'd3; press();
    sw = 4'd5; press();
    chk("subneg_result", int'(result), 2);
    chk("subneg_carry", int'(carryOut), 1);
    chk("subneg_s", int'(s), 1);
    op_sel = 1'b0;
    wait_cycles(4);
    chk("show_s_frozen", int'(s), 1);
    press();

    // Subtract positive and equal operands
    op_sel = 1'b1; sw = 4'd5; press();
    sw = 4'd3; press();
    chk("subpos_result", int'(result), 2);
    chk("subpos_carry", int'(carryOut), 0);
    press();
    sw = 4'd7; press();
    press();
    chk("subeq_result", int'(result), 0);
    chk("subeq_carry", int'(carryOut), 0);
    press();

    // Bounce rejected, a genuine press steps once
    sw = 4'd4; op_sel = 1'b0;
    bounce(3);
    chk("bounce_state", int'(state), 0);
    press();
    chk("step_state", int'(state), 1);
    chk("step_a", int'(operand_a), 4);

    // Reset mid-sequence, then a full cycle back to LOAD_A
    press(); press();
    sw = 4'd6; press();
    chk("preset_a", int'(operand_a), 6);
    do_reset();
    wait_cycles(2);
    chk("midrst_state", int'(state), 0);
    chk("midrst_a", int'(operand_a), 0);
    sw = 4'd2; press();
    sw = 4'd1; press();
    chk("r_show_state", int'(state), 2);
    press();
    chk("wrap_state", int'(state), 0);
    chk("wrap_carry", int'(carryOut), 0);
    chk("wrap_valid", int'(result_valid), 0);

    // Key held across reset release must not step until re-pressed
    busy  = 1'b1;
    key_n = 1'b0;
    wait_cycles(3);
    do_reset();
    wait_cycles(20);
    chk("held_state", int'(state), 0);
    key_n = 1'b1;
    wait_cycles(12);
    sw = 4'd3; press();
    chk("after_held_state", int'(state), 1);
    chk("after_held_a", int'(operand_a), 3);

    wait_cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
